// File: rtl/pipelined_adder_p_pkg.sv
// Shared sizing for the segmented pipelined adder: default widths and
// the pipeline depth derived from them.
package pipelined_adder_p_pkg;

    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_SEG   = 32;

    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/pipelined_adder_p_seg_adder.sv
// Combinational SEG-bit adder slice; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module seg_adder
    import pipelined_adder_p_pkg::*;
#(
    parameter int SEG = DEFAULT_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum   = full[SEG-1:0];
    assign cout  = full[SEG];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign c_msb = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];

endmodule

// File: rtl/pipelined_adder_p.sv
// Add/subtract pipeline that sums one SEG-bit slice per stage, carrying the
// not-yet-added operand bits forward in shrinking skew registers.
module pipelined_adder_p
    import pipelined_adder_p_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages_of(WIDTH, SEG);

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = k * SEG;
        localparam int REM  = WIDTH - DONE;

        logic [REM-1:0]      a_rem;
        logic [REM-1:0]      b_rem;
        logic [DONE+SEG-1:0] res_d;
        logic [DONE+SEG-1:0] res_q;
        logic                valid_in;
        logic                sub_in;
        logic                carry_in;
        logic                v_q;
        logic                c_q;
        logic [SEG-1:0]      seg_b;
        logic [SEG-1:0]      seg_sum;
        logic                seg_cout;
        logic                seg_cmsb;

        // Subtraction is a + ~b + ~cin; the mode bit rides along with each beat.
        if (k == 0) begin : g_src
            assign a_rem    = a;
            assign b_rem    = b;
            assign valid_in = in_valid;
            assign sub_in   = sub;
            assign carry_in = sub ? ~cin : cin;
            assign res_d    = seg_sum;
        end else begin : g_src
            assign a_rem    = g_stage[k-1].g_skew.a_q;
            assign b_rem    = g_stage[k-1].g_skew.b_q;
            assign valid_in = g_stage[k-1].v_q;
            assign sub_in   = g_stage[k-1].g_skew.sub_q;
            assign carry_in = g_stage[k-1].c_q;
            assign res_d    = {seg_sum, g_stage[k-1].res_q};
        end

        assign seg_b = sub_in ? ~b_rem[SEG-1:0] : b_rem[SEG-1:0];

        seg_adder #(.SEG(SEG)) u_seg (
            .a    (a_rem[SEG-1:0]),
            .b    (seg_b),
            .cin  (carry_in),
            .sum  (seg_sum),
            .cout (seg_cout),
            .c_msb(seg_cmsb)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (en) begin
                v_q   <= valid_in;
                c_q   <= seg_cout;
                res_q <= res_d;
            end
        end

        // Only the top slice's MSB carry is meaningful for signed overflow.
        if (k < STAGES - 1) begin : g_skew
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;
            logic               sub_q;
            logic               unused_cmsb;

            assign unused_cmsb = seg_cmsb;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (en) begin
                    a_q   <= a_rem[REM-1:SEG];
                    b_q   <= b_rem[REM-1:SEG];
                    sub_q <= sub_in;
                end
            end
        end else begin : g_out
            logic ovf_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= seg_cmsb ^ seg_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].res_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipelined_adder_p.sv
// Directed bench for pipelined_adder_p: corner-case sums, a back-to-back
// stream, a downstream stall and a mid-flight reset, scored in order.
module tb_pipelined_adder_p;

    localparam int WIDTH  = 128;
    localparam int SEG    = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        bit               check_lat;
        int               acc_cycle;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t exp_q[$];
    exp_t got;
    exp_t held;
    int   cycle_cnt   = 0;
    int   error_count = 0;
    int   check_count = 0;

    pipelined_adder_p #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Golden result computed monolithically; overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input logic s);
        exp_t             r;
        logic [WIDTH-1:0] y_eff;
        logic             c_eff;
        logic [WIDTH:0]   full;
        y_eff       = s ? ~y : y;
        c_eff       = s ? ~c : c;
        full        = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};
        r.sum       = full[WIDTH-1:0];
        r.cout      = full[WIDTH];
        r.ovf       = (x[WIDTH-1] == y_eff[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
        r.check_lat = 1'b1;
        r.acc_cycle = 0;
        return r;
    endfunction

    function automatic exp_t hand(input logic [WIDTH-1:0] s, input logic c, input logic o);
        exp_t r;
        r.sum       = s;
        r.cout      = c;
        r.ovf       = o;
        r.check_lat = 1'b1;
        r.acc_cycle = 0;
        return r;
    endfunction

    // Called just after a rising edge; returns one edge later with in_valid low.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s, input exp_t e);
        int waited;
        waited   = 0;
        a        = x;
        b        = y;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", WIDTH'(in_ready), WIDTH'(1'b1));
        end else begin
            e.acc_cycle = cycle_cnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, WIDTH'(exp_q.size()), WIDTH'(0));
    endtask

    always @(posedge clk) begin
        #3;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_result", WIDTH'(out_valid), WIDTH'(1'b0));
            end else begin
                got = exp_q.pop_front();
                checkOutput("sum", sum, got.sum);
                checkOutput("cout", WIDTH'(cout), WIDTH'(got.cout));
                checkOutput("ovf", WIDTH'(ovf), WIDTH'(got.ovf));
                if (got.check_lat)
                    checkOutput("latency", WIDTH'(cycle_cnt - got.acc_cycle), WIDTH'(STAGES));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=running required=done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             c;
        logic             s;
        exp_t             e;

        clk       = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        #12;
        $display("[TB] reset state");
        checkOutput("rst_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        checkOutput("rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        checkOutput("rst_sum", sum, '0);
        checkOutput("rst_cout", WIDTH'(cout), WIDTH'(1'b0));
        checkOutput("rst_ovf", WIDTH'(ovf), WIDTH'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed corner cases");
        applyStimulus({WIDTH{1'b1}}, WIDTH'(1), 1'b0, 1'b0, hand('0, 1'b1, 1'b0));
        applyStimulus({1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0, 1'b0,
                      hand({1'b1, {(WIDTH-1){1'b0}}}, 1'b0, 1'b1));
        applyStimulus(WIDTH'(5), WIDTH'(7), 1'b0, 1'b1,
                      hand({{(WIDTH-1){1'b1}}, 1'b0}, 1'b0, 1'b0));
        applyStimulus(WIDTH'(128'hFFFF_FFFF), '0, 1'b1, 1'b0,
                      hand(WIDTH'(128'h1_0000_0000), 1'b0, 1'b0));
        applyStimulus(WIDTH'(10), WIDTH'(3), 1'b1, 1'b1, hand(WIDTH'(6), 1'b1, 1'b0));
        applyStimulus({1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1), 1'b0, 1'b1,
                      hand({1'b0, {(WIDTH-1){1'b1}}}, 1'b1, 1'b1));
        waitDrain("drain_directed");

        $display("[TB] back-to-back stream");
        for (int i = 0; i < 8; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            y = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = 1'($urandom_range(1, 0));
            s = i[0];
            e = model(x, y, c, s);
            applyStimulus(x, y, c, s, e);
        end
        waitDrain("drain_stream");

        $display("[TB] downstream stall");
        for (int i = 0; i < 4; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            y = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = 1'($urandom_range(1, 0));
            s = (i == 1 || i == 2);
            e = model(x, y, c, s);
            e.check_lat = 1'b0;
            if (i == 0) held = e;
            applyStimulus(x, y, c, s, e);
        end
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
            checkOutput("stall_out_valid", WIDTH'(out_valid), WIDTH'(1'b1));
            checkOutput("stall_sum", sum, held.sum);
            checkOutput("stall_cout", WIDTH'(cout), WIDTH'(held.cout));
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            y = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = 1'($urandom_range(1, 0));
            s = i[0];
            e = model(x, y, c, s);
            applyStimulus(x, y, c, s, e);
        end
        waitDrain("drain_stall");

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            y = {$urandom(), $urandom(), $urandom(), $urandom()};
            e = model(x, y, 1'b0, 1'b0);
            applyStimulus(x, y, 1'b0, 1'b0, e);
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_out_valid", WIDTH'(out_valid), WIDTH'(1'b1));
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        checkOutput("mid_rst_sum", sum, '0);
        checkOutput("mid_rst_cout", WIDTH'(cout), WIDTH'(1'b0));
        checkOutput("mid_rst_ovf", WIDTH'(ovf), WIDTH'(1'b0));
        checkOutput("mid_rst_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        exp_q.delete();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(WIDTH'(3), WIDTH'(4), 1'b1, 1'b0, hand(WIDTH'(8), 1'b0, 1'b0));
        waitDrain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
